// File: rtl/stg_mo.sv
// stg_mo: memory-operation stage between EX and WB.
// Issues loads/stores on a req/ack bus, stalls EX, and faults on timeout.
//
// Ports:
//   iw_clk, iw_rst_n           clock, async active-low reset
//   iw_flush                   kill the incoming EX bundle
//   iw_pc .. iw_sr_result      EX result bundle
//   ow_stall                   hold EX (combinational)
//   ow_mem_req/we/addr/wdata   memory request (registered)
//   iw_mem_ack, iw_mem_rdata   memory completion and load data
//   ow_pc .. ow_sr_result      registered bundle to WB
//   ow_fault                   one-cycle pulse on access timeout
module stg_mo #(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 48,
  parameter int OPC_W   = 8,
  parameter int GP_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_flush,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [OPC_W-1:0]  iw_opc,
  input  logic              iw_mem_rd,
  input  logic              iw_mem_wr,
  input  logic [ADDR_W-1:0] iw_addr,
  input  logic [DATA_W-1:0] iw_result,
  input  logic [GP_W-1:0]   iw_tgt_gp,
  input  logic              iw_tgt_gp_we,
  input  logic [GP_W-1:0]   iw_tgt_ar,
  input  logic              iw_tgt_ar_we,
  input  logic [ADDR_W-1:0] iw_ar_result,
  input  logic [GP_W-1:0]   iw_tgt_sr,
  input  logic              iw_tgt_sr_we,
  input  logic [ADDR_W-1:0] iw_sr_result,
  output logic              ow_stall,
  output logic              ow_mem_req,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic              iw_mem_ack,
  input  logic [DATA_W-1:0] iw_mem_rdata,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [OPC_W-1:0]  ow_opc,
  output logic [DATA_W-1:0] ow_result,
  output logic [GP_W-1:0]   ow_tgt_gp,
  output logic              ow_tgt_gp_we,
  output logic [GP_W-1:0]   ow_tgt_ar,
  output logic              ow_tgt_ar_we,
  output logic [ADDR_W-1:0] ow_ar_result,
  output logic [GP_W-1:0]   ow_tgt_sr,
  output logic              ow_tgt_sr_we,
  output logic [ADDR_W-1:0] ow_sr_result,
  output logic              ow_fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] result;
    logic [GP_W-1:0]   tgt_gp;
    logic              gp_we;
    logic [GP_W-1:0]   tgt_ar;
    logic              ar_we;
    logic [ADDR_W-1:0] ar_result;
    logic [GP_W-1:0]   tgt_sr;
    logic              sr_we;
    logic [ADDR_W-1:0] sr_result;
  } wb_t;

  state_t     state, state_nx;
  wb_t        in_b, hold_q, wb_d, wb_q;
  logic [CNT_W-1:0] cnt;
  logic       squash_q;
  logic       mem_op;
  logic       ack_ok;
  logic       tmo;
  logic       fault_q;

  always_comb begin
    in_b.pc        = iw_pc;
    in_b.opc       = iw_opc;
    in_b.result    = iw_result;
    in_b.tgt_gp    = iw_tgt_gp;
    in_b.gp_we     = iw_tgt_gp_we;
    in_b.tgt_ar    = iw_tgt_ar;
    in_b.ar_we     = iw_tgt_ar_we;
    in_b.ar_result = iw_ar_result;
    in_b.tgt_sr    = iw_tgt_sr;
    in_b.sr_we     = iw_tgt_sr_we;
    in_b.sr_result = iw_sr_result;
  end

  assign mem_op = iw_mem_rd | iw_mem_wr;
  assign ack_ok = (state == S_REQ) && iw_mem_ack;
  // Ack wins over a timeout landing on the same edge.
  assign tmo    = (state == S_REQ) && !iw_mem_ack
                  && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) state <= S_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ow_stall = 1'b0;
    wb_d     = '0;
    unique case (state)
      S_IDLE: begin
        if (!iw_flush) begin
          if (mem_op) begin
            ow_stall = 1'b1;
            state_nx = S_REQ;
          end else begin
            wb_d = in_b;
          end
        end
      end
      S_REQ: begin
        ow_stall = 1'b1;
        if (ack_ok) begin
          state_nx = S_IDLE;
          wb_d     = hold_q;
          if (!ow_mem_we) wb_d.result = iw_mem_rdata;
          // Stores never write back; a flush seen during
          // the access squashes the bundle too.
          if (ow_mem_we || squash_q || iw_flush) begin
            wb_d.gp_we = 1'b0;
            wb_d.ar_we = 1'b0;
            wb_d.sr_we = 1'b0;
          end
        end else if (tmo) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      wb_q         <= '0;
      hold_q       <= '0;
      fault_q      <= 1'b0;
      squash_q     <= 1'b0;
      cnt          <= '0;
      ow_mem_req   <= 1'b0;
      ow_mem_we    <= 1'b0;
      ow_mem_addr  <= '0;
      ow_mem_wdata <= '0;
    end else begin
      wb_q    <= wb_d;
      fault_q <= tmo;
      if (state == S_IDLE && state_nx == S_REQ) begin
        ow_mem_req   <= 1'b1;
        ow_mem_we    <= iw_mem_wr;
        ow_mem_addr  <= iw_addr;
        ow_mem_wdata <= iw_mem_wr ? iw_result : '0;
        hold_q       <= in_b;
        squash_q     <= 1'b0;
        cnt          <= '0;
      end else if (state == S_REQ) begin
        if (ack_ok || tmo) begin
          ow_mem_req   <= 1'b0;
          ow_mem_we    <= 1'b0;
          ow_mem_addr  <= '0;
          ow_mem_wdata <= '0;
          squash_q     <= 1'b0;
          cnt          <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          if (iw_flush) squash_q <= 1'b1;
        end
      end
    end
  end

  assign ow_pc        = wb_q.pc;
  assign ow_opc       = wb_q.opc;
  assign ow_result    = wb_q.result;
  assign ow_tgt_gp    = wb_q.tgt_gp;
  assign ow_tgt_gp_we = wb_q.gp_we;
  assign ow_tgt_ar    = wb_q.tgt_ar;
  assign ow_tgt_ar_we = wb_q.ar_we;
  assign ow_ar_result = wb_q.ar_result;
  assign ow_tgt_sr    = wb_q.tgt_sr;
  assign ow_tgt_sr_we = wb_q.sr_we;
  assign ow_sr_result = wb_q.sr_result;
  assign ow_fault     = fault_q;

endmodule
